// File: rtl/bitr_pkg.sv
// Shared constants for the 3x5 block de-interleaver: geometry, counter widths
// and the natural-order read address sequence.
package bitr_pkg;

  localparam int ROWS = 3;
  localparam int COLS = 5;
  localparam int N    = ROWS * COLS;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ADDR_W = cw(N);
  localparam int ROW_W  = cw(ROWS);
  localparam int COL_W  = cw(COLS);

  localparam int RD_SEQ [N] = '{0, 3, 6, 9, 12, 1, 4, 7, 10, 13, 2, 5, 8, 11, 14};

endpackage

// File: rtl/bitr_deint_addr_gen.sv
// Walks rd_addr = c*ROWS + r in row-major order by stepping it, so no
// multiplier is needed.
module bitr_deint_addr_gen #(
  parameter  int ROWS = bitr_pkg::ROWS,
  parameter  int COLS = bitr_pkg::COLS,
  localparam int AW   = bitr_pkg::cw(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  input  logic          clr_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  import bitr_pkg::*;

  localparam int RW = cw(ROWS);
  localparam int CW = cw(COLS);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          c_end;

  assign c_end  = (c_q == CW'(COLS - 1));
  assign last_o = c_end && (r_q == RW'(ROWS - 1));
  assign addr_o = addr_q;

  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    addr_d = addr_q;
    if (clr_i || (adv_i && last_o)) begin
      r_d    = '0;
      c_d    = '0;
      addr_d = '0;
    end else if (adv_i && c_end) begin
      // End of a row: next row starts at column 0, i.e. address r+1.
      r_d    = r_q + 1'b1;
      c_d    = '0;
      addr_d = AW'(r_q) + AW'(1);
    end else if (adv_i) begin
      c_d    = c_q + 1'b1;
      addr_d = addr_q + AW'(ROWS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/bitr_deint_buf.sv
// Ping-pong de-interleave buffer: samples are written linearly into one bank
// while the other bank is drained in natural (row-major) order.
module bitr_deint_buf #(
  parameter  int DATA_W = 8,
  parameter  int ROWS   = bitr_pkg::ROWS,
  parameter  int COLS   = bitr_pkg::COLS,
  localparam int N      = ROWS * COLS,
  localparam int AW     = bitr_pkg::cw(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  import bitr_pkg::*;

  logic [1:0]             full_q, full_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [AW-1:0]          rd_addr;
  logic                   rd_end;
  logic                   wr_fire, wr_last, rd_fire, rd_last;
  logic [1:0][DATA_W-1:0] bank_rd;

  assign s_ready = ~full_q[wr_sel_q];
  assign m_valid = full_q[rd_sel_q];
  assign m_data  = m_valid ? bank_rd[rd_sel_q] : '0;
  assign m_last  = m_valid & rd_end;

  assign wr_fire = s_valid & s_ready;
  assign wr_last = wr_fire & (wr_addr_q == AW'(N - 1));
  assign rd_fire = m_valid & m_ready;
  assign rd_last = rd_fire & rd_end;

  bitr_deint_addr_gen #(.ROWS(ROWS), .COLS(COLS)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (rd_fire),
    .clr_i  (1'b0),
    .addr_o (rd_addr),
    .last_o (rd_end)
  );

  // Banks hold no reset; the full flags alone decide what is valid.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
      if (wr_fire && (wr_sel_q == 1'(b))) mem_q[wr_addr_q] <= s_data;
    end

    assign bank_rd[b] = mem_q[rd_addr];
  end

  always_comb begin
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_addr_d = wr_addr_q;
    if (wr_fire) wr_addr_d = wr_addr_q + AW'(1);
    // The filling bank is never full, so it can never be the draining bank.
    if (wr_last) begin
      wr_addr_d        = '0;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (rd_last) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_addr_q <= wr_addr_d;
    end
  end

endmodule
